led_cmd_sched: RTL and testbench

Command scheduler sitting between the MIPS memory-mapped I/O port and led_driver (the serial LED controller driver).
- Holds an 8-digit frame buffer plus an intensity register.
- Runs a fixed power-up init sequence, then issues only changed digit/intensity words to led_driver through the IR_START/IR_READY handshake.
- Never lets the CPU stall on the serial link.

---
 rtl/led_defs.sv | 47 ++++
 rtl/led_cmd_sched_if.sv | 20 ++
 rtl/led_dirty_pick.sv | 25 ++
 rtl/led_cmd_sched.sv | 167 ++++++++++++++++
 tb/tb_led_cmd_sched.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/led_defs.sv
// Shared constants, encodings and init ROM for the LED command scheduler.
package led_defs;

  localparam logic [3:0] REG_DIGIT0    = 4'd1;
  localparam logic [3:0] REG_DECODE    = 4'd9;
  localparam logic [3:0] REG_INTENSITY = 4'd10;
  localparam logic [3:0] REG_SCANLIM   = 4'd11;
  localparam logic [3:0] REG_SHUTDOWN  = 4'd12;
  localparam logic [3:0] REG_TEST      = 4'd15;

  localparam int ROM_LEN = 6;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_SELECT,
    ST_ISSUE,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_IDLE
  } state_t;

  typedef enum logic [1:0] {
    K_ROM,
    K_INT,
    K_DIG
  } kind_t;

  function automatic logic [15:0] rom_word(
    input logic [3:0] ptr,
    input logic [3:0] inten,
    input logic [2:0] slim
  );
    logic [15:0] w;
    w = '0;
    case (ptr)
      4'd0:    w = {4'h0, REG_SHUTDOWN, 8'h00};
      4'd1:    w = {4'h0, REG_DECODE, 8'h00};
      4'd2:    w = {4'h0, REG_INTENSITY, 4'h0, inten};
      4'd3:    w = {4'h0, REG_SCANLIM, 5'h00, slim};
      4'd4:    w = {4'h0, REG_TEST, 8'h00};
      4'd5:    w = {4'h0, REG_SHUTDOWN, 8'h01};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/led_cmd_sched_if.sv
// CPU-side memory-mapped write bus into the LED command scheduler.
interface led_cmd_sched_if;

  logic       in_we;
  logic [2:0] in_addr;
  logic [7:0] in_wdata;
  logic       in_int_we;
  logic [3:0] in_int;

  modport master (
    output in_we, in_addr, in_wdata,
    output in_int_we, in_int
  );

  modport slave (
    input in_we, in_addr, in_wdata,
    input in_int_we, in_int
  );

endinterface

// File: rtl/led_dirty_pick.sv
// Round-robin pick of the first dirty digit at or above rr_ptr, wrapping.
module led_dirty_pick #(
  parameter int DIGITS = 8
) (
  input  logic [DIGITS-1:0] dirty,
  input  logic [2:0]        rr_ptr,
  output logic [2:0]        idx,
  output logic              valid
);

  always_comb begin
    int c;
    c     = 0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      c = (int'(rr_ptr) + i) % DIGITS;
      if (!valid && dirty[c]) begin
        valid = 1'b1;
        idx   = 3'(c);
      end
    end
  end

endmodule

// File: rtl/led_cmd_sched.sv
// Frame buffer plus scheduler feeding changed words to led_driver.
module led_cmd_sched
  import led_defs::*;
#(
  parameter int         DIGITS         = 8,
  parameter logic [3:0] INIT_INTENSITY = 4'h8,
  parameter logic [2:0] SCAN_LIMIT     = 3'd7
) (
  input  logic            in_clk,
  input  logic            in_rst,
  led_cmd_sched_if.slave  cpu,
  output logic            out_init_done,
  output logic            out_busy,
  output logic [15:0]     out_CMD,
  output logic            out_IR_START,
  input  logic            in_IR_READY
);

  localparam logic [3:0] ROM_END  = 4'(ROM_LEN);
  localparam logic [3:0] INIT_END = 4'(ROM_LEN + DIGITS);
  localparam logic [2:0] LAST     = 3'(DIGITS - 1);

  state_t            state_q, state_d;
  kind_t             kind_q, kind_d;
  logic [3:0]        init_ptr_q, init_ptr_d;
  logic [7:0]        digit_q [DIGITS];
  logic [7:0]        digit_d [DIGITS];
  logic [DIGITS-1:0] dirty_q, dirty_d;
  logic              int_dirty_q, int_dirty_d;
  logic [3:0]        intensity_q, intensity_d;
  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic [2:0]        sel_q, sel_d;
  logic [15:0]       cmd_q, cmd_d;
  logic [1:0]        wl_cnt_q, wl_cnt_d;

  logic [DIGITS-1:0] wr_set;
  logic              int_set;
  logic              rom_phase;
  logic              done;
  logic [2:0]        pick_idx;
  logic              pick_valid;

  led_dirty_pick #(.DIGITS(DIGITS)) u_pick (
    .dirty  (dirty_q),
    .rr_ptr (rr_ptr_q),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign rom_phase = init_ptr_q < ROM_END;
  // Once the intensity ROM word is captured, later writes must be resent.
  assign int_set   = cpu.in_int_we && (init_ptr_q >= 4'd2);

  always_comb begin
    wr_set = '0;
    if (cpu.in_we && int'(cpu.in_addr) < DIGITS) begin
      wr_set[cpu.in_addr] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    init_ptr_d  = init_ptr_q;
    digit_d     = digit_q;
    dirty_d     = dirty_q;
    int_dirty_d = int_dirty_q;
    intensity_d = intensity_q;
    rr_ptr_d    = rr_ptr_q;
    sel_d       = sel_q;
    cmd_d       = cmd_q;
    wl_cnt_d    = wl_cnt_q;
    done        = 1'b0;

    unique case (state_q)
      ST_INIT, ST_SELECT: begin
        if (rom_phase) begin
          cmd_d   = rom_word(init_ptr_q, intensity_q,
                             SCAN_LIMIT);
          kind_d  = K_ROM;
          state_d = ST_ISSUE;
        end else if (int_dirty_q) begin
          cmd_d       = {4'h0, REG_INTENSITY, 4'h0,
                         intensity_q};
          kind_d      = K_INT;
          int_dirty_d = 1'b0;
          state_d     = ST_ISSUE;
        end else if (pick_valid) begin
          cmd_d    = {4'h0, REG_DIGIT0 + {1'b0, pick_idx},
                      digit_q[pick_idx]};
          kind_d   = K_DIG;
          sel_d    = pick_idx;
          dirty_d[pick_idx] = 1'b0;
          state_d  = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        wl_cnt_d = '0;
        if (in_IR_READY) state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!in_IR_READY)          state_d  = ST_WAIT_HIGH;
        else if (wl_cnt_q == 2'd3) done     = 1'b1;
        else                       wl_cnt_d = wl_cnt_q + 2'd1;
      end
      ST_WAIT_HIGH: begin
        if (in_IR_READY) done = 1'b1;
      end
      ST_IDLE: begin
        if (|(dirty_q | wr_set) || int_dirty_q || int_set)
          state_d = ST_SELECT;
      end
      default: state_d = ST_INIT;
    endcase

    if (done) begin
      state_d = ST_SELECT;
      if (kind_q == K_DIG)
        rr_ptr_d = (sel_q == LAST) ? 3'd0 : sel_q + 3'd1;
      if (init_ptr_q < INIT_END && kind_q != K_INT)
        init_ptr_d = init_ptr_q + 4'd1;
    end

    // Sets are applied last so a write beats a same-cycle clear.
    dirty_d = dirty_d | wr_set;
    if (int_set) int_dirty_d = 1'b1;
    if (cpu.in_int_we) intensity_d = cpu.in_int;
    if (cpu.in_we && int'(cpu.in_addr) < DIGITS)
      digit_d[cpu.in_addr] = cpu.in_wdata;
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q     <= ST_INIT;
      kind_q      <= K_ROM;
      init_ptr_q  <= '0;
      for (int i = 0; i < DIGITS; i++) digit_q[i] <= '0;
      dirty_q     <= '1;
      int_dirty_q <= 1'b0;
      intensity_q <= INIT_INTENSITY;
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      cmd_q       <= '0;
      wl_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      init_ptr_q  <= init_ptr_d;
      digit_q     <= digit_d;
      dirty_q     <= dirty_d;
      int_dirty_q <= int_dirty_d;
      intensity_q <= intensity_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_q       <= sel_d;
      cmd_q       <= cmd_d;
      wl_cnt_q    <= wl_cnt_d;
    end
  end

  assign out_CMD       = cmd_q;
  assign out_IR_START  = (state_q == ST_ISSUE) && in_IR_READY;
  assign out_busy      = (state_q != ST_IDLE);
  assign out_init_done = (init_ptr_q == INIT_END);

endmodule

// File: tb/tb_led_cmd_sched.sv
// Scoreboard bench for led_cmd_sched with a mock led_driver.
module tb_led_cmd_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready;
  logic        init_done, busy, start;
  logic [15:0] cmd;
  int          rcnt;
  int          n_chk = 0;
  int          n_err = 0;
  int          n_start = 0;
  logic [15:0] sb [$];

  led_cmd_sched_if cpu ();

  led_cmd_sched dut (
    .in_clk        (clk),
    .in_rst        (rst_n),
    .cpu           (cpu),
    .out_init_done (init_done),
    .out_busy      (busy),
    .out_CMD       (cmd),
    .out_IR_START  (start),
    .in_IR_READY   (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, act, exp);
    end
  endtask

  // Mock driver: READY low for 20 cycles after each start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready <= 1'b1;
      rcnt  <= 0;
    end else if (start) begin
      ready <= 1'b0;
      rcnt  <= 20;
    end else if (rcnt != 0) begin
      rcnt <= rcnt - 1;
      if (rcnt == 1) ready <= 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [15:0] e;
    if (start === 1'b1) begin
      n_start++;
      e = 'x;
      if (sb.size() > 0) e = sb.pop_front();
      chk("cmd", 32'(cmd), 32'(e));
    end
  end

  task automatic push_init(input logic [3:0] inten);
    sb.push_back(16'h0C00);
    sb.push_back(16'h0900);
    sb.push_back({12'h0A0, inten});
    sb.push_back(16'h0B07);
    sb.push_back(16'h0F00);
    sb.push_back(16'h0C01);
    for (int i = 1; i <= 8; i++)
      sb.push_back({4'h0, 4'(i), 8'h00});
  endtask

  task automatic wr(input logic [2:0] a,
                    input logic [7:0] d);
    @(negedge clk);
    cpu.in_we    = 1'b1;
    cpu.in_addr  = a;
    cpu.in_wdata = d;
    sb.push_back({4'h0, {1'b0, a} + 4'd1, d});
    @(negedge clk);
    cpu.in_we = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    int k;
    k = 0;
    while (start !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) chk("start_to", 32'(start), 1);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) chk("idle_to", 32'(busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int k;
    cpu.in_we     = 1'b0;
    cpu.in_addr   = '0;
    cpu.in_wdata  = '0;
    cpu.in_int_we = 1'b0;
    cpu.in_int    = '0;
    repeat (2) @(negedge clk);
    chk("rst_cmd", 32'(cmd), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_done", 32'(init_done), 0);
    chk("rst_busy", 32'(busy), 1);

    push_init(4'h8);
    rst_n = 1'b1;
    wait_idle(1000);
    chk("init_done", 32'(init_done), 1);
    chk("init_busy", 32'(busy), 0);
    chk("init_sb", sb.size(), 0);
    chk("init_n", n_start, 14);

    wr(3'd3, 8'h5A);
    chk("lat1", 32'(start), 0);
    @(negedge clk);
    chk("lat2", 32'(start), 1);
    chk("lat_cmd", 32'(cmd), 32'h045A);
    repeat (5) @(negedge clk);
    chk("busy_xfer", 32'(busy), 1);
    wait_idle(200);
    chk("lat_sb", sb.size(), 0);

    wr(3'd6, 8'h11);
    wait_start(50);
    @(negedge clk);
    wr(3'd1, 8'h22);
    wait_idle(200);
    chk("rr_sb", sb.size(), 0);

    s0 = n_start;
    wr(3'd2, 8'hAA);
    wait_start(50);
    @(negedge clk);
    wr(3'd2, 8'hBB);
    wait_idle(200);
    chk("ovr_n", n_start - s0, 2);
    chk("ovr_sb", sb.size(), 0);

    @(negedge clk);
    cpu.in_int_we = 1'b1;
    cpu.in_int    = 4'hF;
    cpu.in_we     = 1'b1;
    cpu.in_addr   = 3'd0;
    cpu.in_wdata  = 8'h00;
    sb.push_back(16'h0A0F);
    sb.push_back(16'h0100);
    @(negedge clk);
    cpu.in_int_we = 1'b0;
    cpu.in_we     = 1'b0;
    wait_idle(200);
    chk("int_sb", sb.size(), 0);

    rst_n = 1'b0;
    @(negedge clk);
    sb.delete();
    push_init(4'h8);
    rst_n = 1'b1;
    k  = 0;
    s0 = 0;
    while (k < 3 && s0 < 500) begin
      @(negedge clk);
      s0++;
      if (start === 1'b1) k++;
    end
    chk("mid_third", k, 3);
    chk("mid_done", 32'(init_done), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_start", 32'(start), 0);
    chk("mid_cmd", 32'(cmd), 0);
    sb.delete();
    push_init(4'h8);
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle(1000);
    chk("re_sb", sb.size(), 0);
    chk("re_done", 32'(init_done), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
